// File: rtl/speck_pkg.sv
// Shared Speck constants and FSM state encoding, used by the encryptor,
// decryptor and key schedule.
package speck_pkg;

   localparam int SPECK_W      = 32;
   localparam int SPECK_ROUNDS = 27;
   localparam int SPECK_ALPHA  = 8;
   localparam int SPECK_BETA   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } speck_state_t;

endpackage

// File: rtl/speck_round_inv.sv
// One combinational Speck inverse round; mirror of the encryptor round.
// y' = ROR(x ^ y, BETA), x' = ROL((x ^ k) - y', ALPHA), all mod 2^W.
module speck_round_inv
   import speck_pkg::*;
#(
   parameter int W = SPECK_W
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] k,
   output logic [W-1:0] x_next,
   output logic [W-1:0] y_next
);

   logic [W-1:0] xy;
   logic [W-1:0] diff;

   assign xy     = x ^ y;
   assign y_next = (xy >> SPECK_BETA) | (xy << (W - SPECK_BETA));
   assign diff   = (x ^ k) - y_next;
   assign x_next = (diff << SPECK_ALPHA) | (diff >> (W - SPECK_ALPHA));

endmodule

// File: rtl/speck_decryptor.sv
// Iterative Speck decryption core, one inverse round per clock, keys used
// from rk[ROUNDS-1] down to rk[0]. Define SPECK_DEC_KEY_LATCH_EN to latch rk_flat on accept.
module speck_decryptor
   import speck_pkg::*;
#(
   parameter int W      = SPECK_W,
   parameter int ROUNDS = SPECK_ROUNDS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [W-1:0]        ct_x,
   input  logic [W-1:0]        ct_y,
   input  logic [W*ROUNDS-1:0] rk_flat,
   output logic [W-1:0]        pt_x,
   output logic [W-1:0]        pt_y,
   output logic                done,
   output logic [1:0]          state_dbg
);

   localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   speck_state_t        state;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        x_q;
   logic [W-1:0]        y_q;
   logic [W-1:0]        x_n;
   logic [W-1:0]        y_n;
   logic [W-1:0]        rk_cur;
   logic [W*ROUNDS-1:0] rk_src;
   logic                accept;

   // start is honoured from IDLE and DONE, never while a block is in flight.
   assign accept = start && (state != ST_RUN);

`ifdef SPECK_DEC_KEY_LATCH_EN
   logic [W*ROUNDS-1:0] rk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rk_q <= '0;
      end else if (accept) begin
         rk_q <= rk_flat;
      end
   end

   assign rk_src = rk_q;
`else
   assign rk_src = rk_flat;
`endif

   assign rk_cur = rk_src[int'(cnt)*W +: W];

   speck_round_inv #(.W(W)) u_round (
      .x      (x_q),
      .y      (y_q),
      .k      (rk_cur),
      .x_next (x_n),
      .y_next (y_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         x_q   <= '0;
         y_q   <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  state <= ST_RUN;
                  x_q   <= ct_x;
                  y_q   <= ct_y;
                  cnt   <= CW'(ROUNDS - 1);
                  done  <= 1'b0;
               end
            end
            ST_RUN: begin
               x_q <= x_n;
               y_q <= y_n;
               if (cnt == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign pt_x      = x_q;
   assign pt_y      = y_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_speck_decryptor.sv
// Self-checking bench for speck_decryptor: forward-encryption reference model,
// expected-result queue drained by a monitor on each rising done.
module tb_speck_decryptor;

   localparam int W      = 32;
   localparam int ROUNDS = 27;
   localparam logic [127:0] KAT_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [63:0]  KAT_CT  = 64'h8c6fa548_454e028b;
   localparam logic [63:0]  KAT_PT  = 64'h3b726574_7475432d;

   logic                clk;
   logic                rst;
   logic                start;
   logic [W-1:0]        ct_x;
   logic [W-1:0]        ct_y;
   logic [W*ROUNDS-1:0] rk_flat;
   logic [W-1:0]        pt_x;
   logic [W-1:0]        pt_y;
   logic                done;
   logic [1:0]          state_dbg;

   logic [64:0]         exp_q[$];
   logic [W*ROUNDS-1:0] rk_fixed;
   int                  n_tests;
   int                  n_fail;

   speck_decryptor #(.W(W), .ROUNDS(ROUNDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ct_x      (ct_x),
      .ct_y      (ct_y),
      .rk_flat   (rk_flat),
      .pt_x      (pt_x),
      .pt_y      (pt_y),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Speck64/128 key expansion: key = {l2, l1, l0, k0}.
   function automatic logic [W*ROUNDS-1:0] expand_key(input logic [127:0] key);
      logic [31:0]         k;
      logic [31:0]         l[0:ROUNDS+2];
      logic [W*ROUNDS-1:0] r;
      k    = key[31:0];
      l[0] = key[63:32];
      l[1] = key[95:64];
      l[2] = key[127:96];
      for (int i = 0; i < ROUNDS - 1; i++) begin
         r[i*32 +: 32] = k;
         l[i+3] = (k + ror32(l[i], 8)) ^ 32'(i);
         k      = rol32(k, 3) ^ l[i+3];
      end
      r[(ROUNDS-1)*32 +: 32] = k;
      return r;
   endfunction

   function automatic logic [63:0] encrypt(input logic [W*ROUNDS-1:0] rk, input logic [63:0] p);
      logic [31:0] x;
      logic [31:0] y;
      x = p[63:32];
      y = p[31:0];
      for (int i = 0; i < ROUNDS; i++) begin
         x = (ror32(x, 8) + y) ^ rk[i*32 +: 32];
         y = rol32(y, 3) ^ x;
      end
      return {x, y};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic        done_q;
      logic [64:0] e;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_q = 1'b0;
         end else begin
            if (done && !done_q) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL spurious_done: got done=1 expected no pending result at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  if (e[64]) check("result", {pt_x, pt_y}, e[63:0]);
               end
            end
            done_q = done;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // poke_kind: 0 none, 1 extra start pulse, 2 zero rk_flat; applied before edge poke_edge+1.
   task automatic do_op(input logic [63:0] ct, input logic [63:0] expv, input bit chk,
                        input int poke_edge, input int poke_kind);
      int lat;
      @(negedge clk);
      ct_x  = ct[63:32];
      ct_y  = ct[31:0];
      start = 1'b1;
      exp_q.push_back({chk, expv});
      @(posedge clk);
      #1;
      start = 1'b0;
      ct_x  = $urandom;
      ct_y  = $urandom;
      lat   = 0;
      do begin
         if (lat == poke_edge) begin
            if (poke_kind == 1) start = 1'b1;
            if (poke_kind == 2) rk_flat = '0;
         end
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
      end while (!done && lat < 100);
      check("latency", 64'(lat), 64'(ROUNDS));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0]         pt;
      logic [127:0]        key;
      logic [W*ROUNDS-1:0] rk_rand;
      int                  rises[$];
      logic                prev;
      bit                  latch_chk;

      n_tests  = 0;
      n_fail   = 0;
      rk_fixed = expand_key(KAT_KEY);
      rk_flat  = rk_fixed;
      start    = 1'b0;
      ct_x     = '0;
      ct_y     = '0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_pt_x", 64'(pt_x), 64'd0);
      check("reset_pt_y", 64'(pt_y), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_state", 64'(state_dbg), 64'd0);
      rst = 1'b0;

      // Known answer
      do_op(KAT_CT, KAT_PT, 1'b1, -1, 0);

      // Round trip with the reference key, then with random keys
      for (int i = 0; i < 50; i++) begin
         pt = {$urandom, $urandom};
         do_op(encrypt(rk_fixed, pt), pt, 1'b1, -1, 0);
      end
      for (int i = 0; i < 10; i++) begin
         key     = {$urandom, $urandom, $urandom, $urandom};
         rk_rand = expand_key(key);
         rk_flat = rk_rand;
         pt      = {$urandom, $urandom};
         do_op(encrypt(rk_rand, pt), pt, 1'b1, -1, 0);
      end
      rk_flat = rk_fixed;

      // start during RUN is ignored
      do_op(KAT_CT, KAT_PT, 1'b1, 10, 1);
      pt = {$urandom, $urandom};
      do_op(encrypt(rk_fixed, pt), pt, 1'b1, $urandom_range(1, 20), 1);

      // Reset mid-run aborts immediately
      @(negedge clk);
      ct_x  = KAT_CT[63:32];
      ct_y  = KAT_CT[31:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_done", 64'(done), 64'd0);
      check("abort_pt", {pt_x, pt_y}, 64'd0);
      check("abort_state", 64'(state_dbg), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      do_op(KAT_CT, KAT_PT, 1'b1, -1, 0);

      // start held high: back-to-back operations every ROUNDS+1 cycles
      @(negedge clk);
      ct_x  = KAT_CT[63:32];
      ct_y  = KAT_CT[31:0];
      start = 1'b1;
      repeat (3) exp_q.push_back({1'b1, KAT_PT});
      @(posedge clk);
      #1;
      prev = done;
      for (int e = 1; e <= 90; e++) begin
         @(posedge clk);
         #1;
         if (e == 2 * (ROUNDS + 1)) start = 1'b0;
         if (done && !prev) rises.push_back(e);
         if (e == ROUNDS + 1 || e == 2 * (ROUNDS + 1)) check("hold_done_drop", 64'(done), 64'd0);
         prev = done;
      end
      check("hold_rise_count", 64'(rises.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         check("hold_rise_edge", 64'((rises.size() > k) ? rises[k] : -1),
               64'(ROUNDS + k * (ROUNDS + 1)));
      end

      // Key bus cleared one cycle after accept
`ifdef SPECK_DEC_KEY_LATCH_EN
      latch_chk = 1'b1;
`else
      latch_chk = 1'b0;
`endif
      do_op(KAT_CT, KAT_PT, latch_chk, 1, 2);
      rk_flat = rk_fixed;
      do_op(KAT_CT, KAT_PT, 1'b1, -1, 0);

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
